// File: rtl/fetch_branch_unit_if.sv
// Fetch/branch unit bus: instruction-memory handshake, decoder controls
// returned from the control unit, and the PC/link/status outputs.
interface fetch_branch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              ex_done;
  logic              unconditional;
  logic [2:0]        conditional;
  logic              ad_sel;
  logic              halt;
  logic [31:0]       rs_data;
  logic              carry_flag;
  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] link_addr;
  logic              branch_taken;
  logic              halted;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, link_addr, branch_taken, halted,
    input  imem_valid, imem_rdata, ex_done, unconditional, conditional, ad_sel, halt,
           rs_data, carry_flag, br_offset
  );

  // Memory / control-unit / datapath side
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, link_addr, branch_taken, halted,
    output imem_valid, imem_rdata, ex_done, unconditional, conditional, ad_sel, halt,
           rs_data, carry_flag, br_offset
  );
endinterface

// File: rtl/fetch_branch_unit.sv
// Instruction fetch and next-PC stage of KGP-miniRISC.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | one cycle after reset release, imem_valid ignored
// FETCH | imem_req high at pc, waiting for imem_valid
// EXEC  | instr held and valid, waiting for ex_done to resolve next pc
// HALT  | halted, no further fetches; exit only through reset
module fetch_branch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 reset_n,
  fetch_branch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] link_q;
  logic [31:0]       instr_q;
  logic              req_q;
  logic              iv_q;
  logic              bt_q;
  logic              halted_q;

  logic              cond_true;
  logic              taken;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_pc;

  // Evaluate the conditional-branch predicate from the decoded condition code
  always_comb begin
    cond_true = 1'b0;
    case (bus.conditional)
      3'b001:  cond_true = bus.rs_data[31];
      3'b010:  cond_true = (bus.rs_data == 32'd0);
      3'b011:  cond_true = (bus.rs_data != 32'd0);
      3'b100:  cond_true = bus.carry_flag;
      3'b101:  cond_true = ~bus.carry_flag;
      default: cond_true = 1'b0;
    endcase
  end

  assign taken   = bus.unconditional | cond_true;
  assign seq_pc  = pc_q + ADDR_W'(4);
  // Word offset is relative to the instruction after the branch.
  assign target  = bus.ad_sel ? bus.rs_data[ADDR_W-1:0] : seq_pc + (bus.br_offset << 2);
  assign next_pc = taken ? target : seq_pc;

  // Sequencer: fetch handshake, execute/resolve, halt; all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      link_q   <= RESET_PC + ADDR_W'(4);
      instr_q  <= '0;
      req_q    <= 1'b0;
      iv_q     <= 1'b0;
      bt_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      bt_q <= 1'b0;
      case (state)
        IDLE: begin
          req_q <= 1'b1;
          state <= FETCH;
        end
        FETCH: begin
          if (bus.imem_valid) begin
            instr_q <= bus.imem_rdata;
            link_q  <= seq_pc;
            req_q   <= 1'b0;
            iv_q    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (bus.ex_done) begin
            iv_q <= 1'b0;
            // Halt wins over any branch bits and leaves pc untouched.
            if (bus.halt) begin
              halted_q <= 1'b1;
              state    <= HALT;
            end else begin
              pc_q  <= next_pc;
              bt_q  <= taken;
              req_q <= 1'b1;
              state <= FETCH;
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req     = req_q;
  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.instr        = instr_q;
  assign bus.instr_valid  = iv_q;
  assign bus.link_addr    = link_q;
  assign bus.branch_taken = bt_q;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_fetch_branch_unit.sv
module tb_fetch_branch_unit;
  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_pc;

  fetch_branch_unit_if #(.ADDR_W(32)) bus ();

  fetch_branch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: branch rules applied with plain arithmetic, returns {taken, next_pc}
  function automatic logic [32:0] ref_next(input logic [31:0] pc, input logic unc,
                                           input logic [2:0] cnd, input logic ads,
                                           input logic [31:0] rs, input logic cy,
                                           input logic [31:0] off);
    bit take;
    logic [63:0] t;
    case (cnd)
      3'd1: take = ($signed(rs) < 0);
      3'd2: take = (rs == 0);
      3'd3: take = (rs != 0);
      3'd4: take = cy;
      3'd5: take = !cy;
      default: take = 0;
    endcase
    take = take | unc;
    if (!take) t = {32'd0, pc} + 64'd4;
    else if (ads) t = {32'd0, rs};
    else t = {32'd0, pc} + 64'd4 + ({{32{off[31]}}, off} * 64'd4);
    return {take, t[31:0]};
  endfunction

  task automatic clear_ctrl();
    bus.ex_done = 0; bus.unconditional = 0; bus.conditional = 0; bus.ad_sel = 0;
    bus.halt = 0; bus.rs_data = $urandom; bus.carry_flag = 1'($urandom); bus.br_offset = $urandom;
  endtask

  // Wait for a fetch request, insert ws wait states (with stray ex_done), then deliver word
  task automatic fetch(input int ws, input logic [31:0] word);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL fetch_timeout: imem_req=%b required 1", bus.imem_req);
    end
    for (int i = 0; i < ws; i++) begin
      bus.ex_done = 1; bus.unconditional = 1; bus.ad_sel = 1; bus.rs_data = 32'hDEAD_0000;
      @(negedge clk);
    end
    clear_ctrl();
    bus.imem_valid = 1; bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_valid = 0; bus.imem_rdata = $urandom;
  endtask

  // Hold EXEC for dly cycles (with stray imem_valid), then present controls with ex_done
  task automatic exec(input logic unc, input logic [2:0] cnd, input logic ads, input logic hlt,
                      input logic [31:0] rs, input logic cy, input logic [31:0] off, input int dly);
    for (int i = 0; i < dly; i++) begin
      bus.imem_valid = 1; bus.imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
    end
    bus.imem_valid = 0;
    bus.unconditional = unc; bus.conditional = cnd; bus.ad_sel = ads; bus.halt = hlt;
    bus.rs_data = rs; bus.carry_flag = cy; bus.br_offset = off; bus.ex_done = 1;
    @(negedge clk);
    clear_ctrl();
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    fetch(0, 32'h1111_1111);
    exec(1, 3'b000, 1, 0, addr, 0, 0, 0);
    m_pc = addr;
  endtask

  task automatic test_reset();
    reset_n = 0; bus.imem_valid = 1; bus.imem_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.pc !== 32'h0 || bus.instr !== 32'h0 || bus.link_addr !== 32'h4 || bus.imem_req !== 0 ||
        bus.instr_valid !== 0 || bus.branch_taken !== 0 || bus.halted !== 0) begin
      errors++;
      $display("FAIL reset_values: pc=%h instr=%h link=%h req=%b iv=%b bt=%b halted=%b required 0,0,4,0,0,0,0",
               bus.pc, bus.instr, bus.link_addr, bus.imem_req, bus.instr_valid, bus.branch_taken, bus.halted);
    end
    reset_n = 1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 0 || bus.halted !== 0 ||
        bus.instr !== 32'h0) begin
      errors++;
      $display("FAIL after_idle: req=%b addr=%h iv=%b halted=%b instr=%h required 1,0,0,0,0",
               bus.imem_req, bus.imem_addr, bus.instr_valid, bus.halted, bus.instr);
    end
    bus.imem_valid = 0;
    clear_ctrl();
    m_pc = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] words [3] = '{32'h0000_0001, 32'h2222_0000, 32'h3333_3333};
    int ws [3] = '{0, 3, 1};
    for (int i = 0; i < 3; i++) begin
      fetch(ws[i], words[i]);
      checks++;
      if (bus.instr !== words[i] || bus.instr_valid !== 1 || bus.imem_req !== 0 ||
          bus.link_addr !== m_pc + 4 || bus.pc !== m_pc) begin
        errors++;
        $display("FAIL seq_fetch%0d: instr=%h iv=%b req=%b link=%h pc=%h required %h,1,0,%h,%h",
                 i, bus.instr, bus.instr_valid, bus.imem_req, bus.link_addr, bus.pc, words[i], m_pc + 4, m_pc);
      end
      exec(0, 3'b000, 0, 0, $urandom, 1'($urandom), $urandom, i);
      m_pc = m_pc + 4;
      checks++;
      if (bus.pc !== m_pc || bus.branch_taken !== 0) begin
        errors++;
        $display("FAIL seq_pc%0d: pc=%h bt=%b required %h,0", i, bus.pc, bus.branch_taken, m_pc);
      end
    end
  endtask

  task automatic test_cond_branch();
    goto_pc(32'h8);
    fetch(1, 32'hAAAA_0001);
    exec(0, 3'b010, 0, 0, 32'h0, 0, 32'd3, 0);
    checks++;
    if (bus.pc !== 32'd24 || bus.branch_taken !== 1) begin
      errors++; $display("FAIL bz_taken: pc=%h bt=%b required 18,1", bus.pc, bus.branch_taken);
    end
    @(negedge clk);
    checks++;
    if (bus.branch_taken !== 0) begin
      errors++; $display("FAIL taken_pulse: bt=%b required 0", bus.branch_taken);
    end
    goto_pc(32'h8);
    fetch(0, 32'hAAAA_0002);
    exec(0, 3'b010, 0, 0, 32'd5, 0, 32'd3, 1);
    checks++;
    if (bus.pc !== 32'd12 || bus.branch_taken !== 0) begin
      errors++; $display("FAIL bz_not_taken: pc=%h bt=%b required c,0", bus.pc, bus.branch_taken);
    end
    goto_pc(32'h8);
    fetch(0, 32'hAAAA_0003);
    exec(0, 3'b001, 0, 0, 32'h8000_0000, 0, 32'd3, 0);
    checks++;
    if (bus.pc !== 32'd24 || bus.branch_taken !== 1) begin
      errors++; $display("FAIL bltz_taken: pc=%h bt=%b required 18,1", bus.pc, bus.branch_taken);
    end
  endtask

  task automatic test_reg_branch_link();
    goto_pc(32'h40);
    fetch(0, 32'hBBBB_0001);
    exec(1, 3'b000, 1, 0, 32'h100, 0, 32'h55, 0);
    checks++;
    if (bus.pc !== 32'h100 || bus.branch_taken !== 1) begin
      errors++; $display("FAIL br_reg: pc=%h bt=%b required 100,1", bus.pc, bus.branch_taken);
    end
    goto_pc(32'h20);
    fetch(2, 32'hBBBB_0002);
    checks++;
    if (bus.link_addr !== 32'h24) begin
      errors++; $display("FAIL bl_link_exec: link=%h required 24", bus.link_addr);
    end
    exec(1, 3'b000, 0, 0, $urandom, 0, 32'hFFFF_FFFE, 2);
    checks++;
    if (bus.pc !== 32'h1C || bus.link_addr !== 32'h24 || bus.branch_taken !== 1) begin
      errors++;
      $display("FAIL bl_target: pc=%h link=%h bt=%b required 1c,24,1", bus.pc, bus.link_addr, bus.branch_taken);
    end
  endtask

  task automatic test_carry();
    for (int k = 0; k < 4; k++) begin
      logic [2:0] cnd = (k < 2) ? 3'b100 : 3'b101;
      logic cy = k[0];
      logic holds = (cnd == 3'b100) ? cy : !cy;
      logic [31:0] exp_pc = holds ? 32'd20 : 32'd4;
      goto_pc(32'h0);
      fetch(k, 32'hCCCC_0000 + k);
      exec(0, cnd, 0, 0, $urandom, cy, 32'd4, 0);
      checks++;
      if (bus.pc !== exp_pc || bus.branch_taken !== holds) begin
        errors++;
        $display("FAIL carry_cond%0d: pc=%h bt=%b required %h,%b", k, bus.pc, bus.branch_taken, exp_pc, holds);
      end
    end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    fetch(0, 32'hDDDD_0001);
    checks++;
    if (bus.link_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_link: link=%h required 0", bus.link_addr);
    end
    exec(0, 3'b000, 0, 0, $urandom, 0, $urandom, 0);
    checks++;
    if (bus.pc !== 32'h0 || bus.branch_taken !== 0) begin
      errors++; $display("FAIL wrap_pc: pc=%h bt=%b required 0,0", bus.pc, bus.branch_taken);
    end
  endtask

  task automatic test_random();
    goto_pc(32'h0);
    for (int it = 0; it < 60; it++) begin
      logic unc = ($urandom_range(0, 3) == 0);
      logic [2:0] cnd = 3'($urandom_range(0, 7));
      logic ads = 1'($urandom);
      logic [31:0] rs = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      logic cy = 1'($urandom);
      logic [31:0] off = 32'($urandom_range(0, 63)) - 32'd32;
      logic [31:0] word = $urandom;
      logic [32:0] r = ref_next(m_pc, unc, cnd, ads, rs, cy, off);
      fetch($urandom_range(0, 3), word);
      checks++;
      if (bus.imem_addr !== m_pc || bus.link_addr !== m_pc + 4) begin
        errors++;
        $display("FAIL rand_fetch%0d: addr=%h link=%h required %h,%h", it, bus.imem_addr, bus.link_addr, m_pc, m_pc + 4);
      end
      exec(unc, cnd, ads, 0, rs, cy, off, $urandom_range(0, 2));
      checks++;
      if (bus.pc !== r[31:0] || bus.branch_taken !== r[32] || bus.instr !== word) begin
        errors++;
        $display("FAIL rand_exec%0d: pc=%h bt=%b instr=%h required %h,%b,%h (unc=%b cnd=%0d ads=%b rs=%h cy=%b off=%h)",
                 it, bus.pc, bus.branch_taken, bus.instr, r[31:0], r[32], word, unc, cnd, ads, rs, cy, off);
      end
      m_pc = r[31:0];
    end
  endtask

  task automatic test_halt();
    fetch(0, 32'hEEEE_0001);
    exec(1, 3'b011, 1, 1, 32'h1234, 1, 32'd7, 1);
    checks++;
    if (bus.halted !== 1 || bus.pc !== m_pc || bus.imem_req !== 0 || bus.instr_valid !== 0 ||
        bus.branch_taken !== 0) begin
      errors++;
      $display("FAIL halt_enter: halted=%b pc=%h req=%b iv=%b bt=%b required 1,%h,0,0,0",
               bus.halted, bus.pc, bus.imem_req, bus.instr_valid, bus.branch_taken, m_pc);
    end
    for (int i = 0; i < 5; i++) begin
      bus.imem_valid = 1; bus.ex_done = 1; bus.unconditional = 1;
      @(negedge clk);
      checks++;
      if (bus.halted !== 1 || bus.imem_req !== 0 || bus.pc !== m_pc) begin
        errors++;
        $display("FAIL halt_hold%0d: halted=%b req=%b pc=%h required 1,0,%h", i, bus.halted, bus.imem_req, bus.pc, m_pc);
      end
    end
    bus.imem_valid = 0;
    clear_ctrl();
  endtask

  task automatic test_reset_mid_fetch();
    reset_n = 0; @(negedge clk); reset_n = 1; @(negedge clk);
    goto_pc(32'h40);
    bus.imem_valid = 1; bus.imem_rdata = 32'hCAFE_F00D;
    #2 reset_n = 0;
    #1;
    checks++;
    if (bus.pc !== 32'h0 || bus.imem_req !== 0 || bus.instr !== 32'h0 || bus.link_addr !== 32'h4) begin
      errors++;
      $display("FAIL async_reset: pc=%h req=%b instr=%h link=%h required 0,0,0,4", bus.pc, bus.imem_req, bus.instr, bus.link_addr);
    end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 0 || bus.imem_req !== 1 || bus.instr !== 32'h0) begin
      errors++;
      $display("FAIL response_dropped: iv=%b req=%b instr=%h required 0,1,0", bus.instr_valid, bus.imem_req, bus.instr);
    end
    bus.imem_valid = 0;
    fetch(1, 32'h5A5A_0001);
    checks++;
    if (bus.instr !== 32'h5A5A_0001 || bus.pc !== 32'h0 || bus.instr_valid !== 1) begin
      errors++;
      $display("FAIL refetch_after_reset: instr=%h pc=%h iv=%b required 5a5a0001,0,1", bus.instr, bus.pc, bus.instr_valid);
    end
  endtask

  initial begin
    reset_n = 0;
    bus.imem_valid = 0; bus.imem_rdata = 0;
    clear_ctrl();
    test_reset();
    test_sequential();
    test_cond_branch();
    test_reg_branch_link();
    test_carry();
    test_wrap();
    test_random();
    test_halt();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
